// File: rtl/rr_pkg.sv
// Shared definitions for the RR-interval tracker: FSM encoding, buffer depth
// and the shift amounts used by the shift-add interval limits.
package rr_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FIRST = 2'd1,
        S_TRACK = 2'd2
    } rr_state_t;

    localparam int RR_DEPTH    = 8;
    localparam int RR_DEPTH_SH = 3;

    // LOW  = A - A/16 - A/64             (~92%)
    localparam int LOW_SH_A  = 4;
    localparam int LOW_SH_B  = 6;
    // HIGH = A + A/8 + A/32              (~116%)
    localparam int HIGH_SH_A = 3;
    localparam int HIGH_SH_B = 5;
    // MISS = A + A/2 + A/8 + A/32        (~166%)
    localparam int MISS_SH_A = 1;
    localparam int MISS_SH_B = 3;
    localparam int MISS_SH_C = 5;

endpackage

// File: rtl/rr_interval_tracker_avg8.sv
// rr_avg8: 8-entry circular interval buffer with a running sum.
// seed fills every slot with din, copy loads a full oldest-first image,
// push overwrites the oldest slot. entries[] is presented oldest-first.
module rr_avg8
    import rr_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic                  seed,
    input  logic                  copy,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [DATA_WIDTH-1:0] copy_in [RR_DEPTH],
    input  logic [DATA_WIDTH+2:0] copy_sum,
    output logic [DATA_WIDTH-1:0] avg,
    output logic [DATA_WIDTH+2:0] sum,
    output logic [DATA_WIDTH-1:0] entries [RR_DEPTH]
);

    localparam int SUM_W = DATA_WIDTH + RR_DEPTH_SH;

    logic [DATA_WIDTH-1:0]  mem [RR_DEPTH];
    logic [RR_DEPTH_SH-1:0] ptr;   // oldest slot, also the next write slot

    // Buffer and running-sum update; seed has priority over copy over push
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < RR_DEPTH; i++) mem[i] <= '0;
            ptr <= '0;
            sum <= '0;
        end else if (seed) begin
            for (int i = 0; i < RR_DEPTH; i++) mem[i] <= din;
            ptr <= '0;
            sum <= {din, {RR_DEPTH_SH{1'b0}}};
        end else if (copy) begin
            for (int i = 0; i < RR_DEPTH; i++) mem[i] <= copy_in[i];
            ptr <= '0;
            sum <= copy_sum;
        end else if (push) begin
            mem[ptr] <= din;
            ptr      <= ptr + 1'b1;
            sum      <= sum + SUM_W'(din) - SUM_W'(mem[ptr]);
        end
    end

    assign avg = sum[SUM_W-1:RR_DEPTH_SH];

    // Rotate storage so entries[0] is always the oldest interval
    always_comb begin
        for (int k = 0; k < RR_DEPTH; k++) begin
            entries[k] = mem[ptr + RR_DEPTH_SH'(k)];
        end
    end

endmodule

// File: rtl/rr_interval_tracker.sv
// RR-interval tracker: reads the elapsed-sample counter on each accepted
// R-peak, restarts it, keeps all-beat and in-limit 8-beat averages and
// requests a search-back when the counter runs past 166% of the in-limit mean.
module rr_interval_tracker
    import rr_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int REFRACT    = 40,
    parameter bit MISS_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  beat_valid,
    input  logic [DATA_WIDTH-1:0] counter_val,
    output logic                  counter_start,
    output logic [DATA_WIDTH-1:0] rr_last,
    output logic [DATA_WIDTH-1:0] rr_avg1,
    output logic [DATA_WIDTH-1:0] rr_avg2,
    output logic                  rr_valid,
    output logic                  search_back,
    output logic                  irregular
);

    localparam int LIM_W = DATA_WIDTH + 1;
    localparam int SUM_W = DATA_WIDTH + RR_DEPTH_SH;

    // Clamp a one-bit-wider limit to the counter range
    function automatic logic [DATA_WIDTH-1:0] sat_data(input logic [LIM_W-1:0] v);
        return v[LIM_W-1] ? {DATA_WIDTH{1'b1}} : v[DATA_WIDTH-1:0];
    endfunction

    rr_state_t              state;
    logic [RR_DEPTH_SH-1:0] rej_cnt;
    logic                   miss_flag;

    logic                   accept, in_lim, miss_hit;
    logic                   seed, push1, push2, copy2;
    logic [LIM_W-1:0]       a_ext, lim_low, lim_high, lim_miss_raw;
    logic [DATA_WIDTH-1:0]  lim_miss;
    logic [DATA_WIDTH-1:0]  ent1 [RR_DEPTH];
    logic [DATA_WIDTH-1:0]  ent2_unused [RR_DEPTH];
    logic [DATA_WIDTH-1:0]  copy_vec [RR_DEPTH];
    logic [SUM_W-1:0]       sum1, sum2_unused, copy_sum;

    // Interval limits derived from the in-limit average
    assign a_ext        = {1'b0, rr_avg2};
    assign lim_low      = a_ext - (a_ext >> LOW_SH_A) - (a_ext >> LOW_SH_B);
    assign lim_high     = a_ext + (a_ext >> HIGH_SH_A) + (a_ext >> HIGH_SH_B);
    assign lim_miss_raw = a_ext + (a_ext >> MISS_SH_A) + (a_ext >> MISS_SH_B)
                        + (a_ext >> MISS_SH_C);
    assign lim_miss     = sat_data(lim_miss_raw);

    assign in_lim = ({1'b0, counter_val} >= lim_low) && ({1'b0, counter_val} <= lim_high);

    // Reset gates the strobes so every output reads 0 while rstn is low
    assign accept   = rstn && en && beat_valid
                    && (state == S_IDLE || counter_val >= DATA_WIDTH'(REFRACT));
    assign miss_hit = MISS_EN && en && (state == S_TRACK) && !accept && !miss_flag
                    && (counter_val > lim_miss);

    assign counter_start = accept;
    assign search_back   = miss_hit;

    assign seed  = accept && (state == S_FIRST);
    assign push1 = accept && (state == S_TRACK);
    assign push2 = push1 && in_lim;
    assign copy2 = push1 && !in_lim && (rej_cnt == RR_DEPTH_SH'(RR_DEPTH - 1));

    // Post-push image of buf1 (oldest-first) for the irregular-rhythm reseed
    always_comb begin
        for (int k = 0; k < RR_DEPTH - 1; k++) copy_vec[k] = ent1[k + 1];
        copy_vec[RR_DEPTH-1] = counter_val;
    end
    assign copy_sum = sum1 + SUM_W'(counter_val) - SUM_W'(ent1[0]);

    rr_avg8 #(.DATA_WIDTH(DATA_WIDTH)) u_buf1 (
        .clk      (clk),
        .rstn     (rstn),
        .push     (push1),
        .seed     (seed),
        .copy     (1'b0),
        .din      (counter_val),
        .copy_in  (copy_vec),
        .copy_sum (copy_sum),
        .avg      (rr_avg1),
        .sum      (sum1),
        .entries  (ent1)
    );

    rr_avg8 #(.DATA_WIDTH(DATA_WIDTH)) u_buf2 (
        .clk      (clk),
        .rstn     (rstn),
        .push     (push2),
        .seed     (seed),
        .copy     (copy2),
        .din      (counter_val),
        .copy_in  (copy_vec),
        .copy_sum (copy_sum),
        .avg      (rr_avg2),
        .sum      (sum2_unused),
        .entries  (ent2_unused)
    );

    // Beat-tracking FSM with registered interval outputs and miss bookkeeping
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            rr_last   <= '0;
            rr_valid  <= 1'b0;
            irregular <= 1'b0;
            rej_cnt   <= '0;
            miss_flag <= 1'b0;
        end else begin
            rr_valid <= 1'b0;
            if (accept) begin
                miss_flag <= 1'b0;
                case (state)
                    S_IDLE: state <= S_FIRST;
                    S_FIRST: begin
                        rr_last   <= counter_val;
                        rr_valid  <= 1'b1;
                        rej_cnt   <= '0;
                        irregular <= 1'b0;
                        state     <= S_TRACK;
                    end
                    default: begin
                        rr_last  <= counter_val;
                        rr_valid <= 1'b1;
                        if (in_lim) begin
                            rej_cnt   <= '0;
                            irregular <= 1'b0;
                        end else if (rej_cnt == RR_DEPTH_SH'(RR_DEPTH - 1)) begin
                            rej_cnt   <= '0;
                            irregular <= 1'b1;
                        end else begin
                            rej_cnt <= rej_cnt + 1'b1;
                        end
                    end
                endcase
            end else if (miss_hit) begin
                miss_flag <= 1'b1;
            end
        end
    end

endmodule
